// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and the
// helper that sizes the bit counter.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Counter must index WIDTH-1; a 1-bit counter still covers the WIDTH=2 case.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial
// subtractor; the requester uses master, the subtractor uses slave.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bo is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first through a single
// full-subtractor cell with a registered borrow, WIDTH cycles per result.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] wd_q,     wd_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             ovf_q,    ovf_d;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] wd_next;

  full_subtractor u_cell (
    .x   (a_sr_q[0]),
    .y   (b_sr_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // Each new difference bit enters at the MSB, so after WIDTH shifts the
  // first (LSB) bit has walked down to position 0.
  assign wd_next = {cell_d, wd_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_SHIFT;
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          wd_d     = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          a_msb_d  = bus.a[WIDTH-1];
          b_msb_d  = bus.b[WIDTH-1];
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        wd_d     = wd_next;
        borrow_d = cell_bo;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          diff_d  = wd_next;
          bout_d  = cell_bo;
          // Overflow only when operand signs differ and the result sign
          // disagrees with the minuend.
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the working shift registers are ordinary flops, not a memory, so
  // they are cleared by reset like the rest of the state; an aborted
  // operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands
// against an arithmetic reference, plus handshake and reset scenarios.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference: plain integer arithmetic on the operands' unsigned and signed views.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, sa, sb, sd;
    logic [W-1:0] d;
    logic bo, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    sd = sa - sb;
    d  = W'((ua - ub + (longint'(1) << W)) % (longint'(1) << W));
    bo = (ua < ub);
    ov = (sd < -(longint'(1) << (W-1))) || (sd > (longint'(1) << (W-1)) - 1);
    return {bo, ov, d};
  endfunction

  // Issues one operation and waits (bounded) for done. Entered and left #1
  // after a rising edge with the DUT in IDLE or DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output bit busy_ok);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    edges = 0;
    busy_ok = 1'b1;
    while (!bus.done && edges < 4 * W) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b done=%b bout=%b ovf=%b diff=%h want all 0",
               bus.busy, bus.done, bus.bout, bus.ovf, bus.diff);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{8'h09, 8'h04, 8'h80, 8'h7F, 8'h00, 8'hFF};
    logic [W-1:0] tb [6] = '{8'h04, 8'h09, 8'h01, 8'hFF, 8'h00, 8'hFF};
    logic [W+1:0] exp_res;
    int edges;
    bit busy_ok;
    for (int i = 0; i < 6; i++) begin
      exp_res = ref_sub(ta[i], tb[i]);
      run_op(ta[i], tb[i], edges, busy_ok);
      vectors++;
      if (edges !== W || !busy_ok) begin
        miscompares++;
        $display("FAIL directed_latency[%0d] got %0d edges busy_ok=%b want %0d edges busy_ok=1",
                 i, edges, busy_ok, W);
      end
      vectors++;
      if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== {2'b01, exp_res}) begin
        miscompares++;
        $display("FAIL directed_result[%0d] a=%h b=%h got busy=%b done=%b bout=%b ovf=%b diff=%h want busy=0 done=1 bout=%b ovf=%b diff=%h",
                 i, ta[i], tb[i], bus.busy, bus.done, bus.bout, bus.ovf, bus.diff,
                 exp_res[W+1], exp_res[W], exp_res[W-1:0]);
      end
      @(posedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== {2'b00, exp_res}) begin
        miscompares++;
        $display("FAIL directed_hold[%0d] got busy=%b done=%b bout=%b ovf=%b diff=%h want 0 0 %b %b %h",
                 i, bus.busy, bus.done, bus.bout, bus.ovf, bus.diff,
                 exp_res[W+1], exp_res[W], exp_res[W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic [W+1:0] exp_res;
    int edges;
    bit busy_ok;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      exp_res = ref_sub(ra, rb);
      run_op(ra, rb, edges, busy_ok);
      vectors++;
      if (edges !== W || !busy_ok || {bus.done, bus.bout, bus.ovf, bus.diff} !== {1'b1, exp_res}) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h got edges=%0d busy_ok=%b done=%b bout=%b ovf=%b diff=%h want edges=%0d done=1 bout=%b ovf=%b diff=%h",
                 i, ra, rb, edges, busy_ok, bus.done, bus.bout, bus.ovf, bus.diff,
                 W, exp_res[W+1], exp_res[W], exp_res[W-1:0]);
      end
      // Alternate between returning to IDLE and restarting straight from DONE.
      if (i % 2 == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] a0, b0;
    logic [W+1:0] exp_res, got_res;
    int done_count, done_edge;
    a0 = W'($urandom);
    b0 = W'($urandom);
    exp_res = ref_sub(a0, b0);
    got_res = '0;
    done_count = 0;
    done_edge = -1;
    bus.start = 1'b1;
    bus.a = a0;
    bus.b = b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 2 * W + 2; e++) begin
      if (e == 3) begin
        bus.start = 1'b1;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        done_count++;
        if (done_edge < 0) begin
          done_edge = e;
          got_res = {bus.bout, bus.ovf, bus.diff};
        end
      end
    end
    vectors++;
    if (done_count !== 1 || done_edge !== W) begin
      miscompares++;
      $display("FAIL start_ignored_done got %0d pulses first at edge %0d want 1 pulse at edge %0d",
               done_count, done_edge, W);
    end
    vectors++;
    if (got_res !== exp_res) begin
      miscompares++;
      $display("FAIL start_ignored_result got %h want %h", got_res, exp_res);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a0, b0;
    logic [W+1:0] first_res, second_res;
    int edges, held_bad;
    bit busy_ok;
    a0 = W'($urandom);
    b0 = W'($urandom);
    first_res = ref_sub(a0, b0);
    second_res = ref_sub(8'h10, 8'h20);
    run_op(a0, b0, edges, busy_ok);
    vectors++;
    if (!bus.done || {bus.bout, bus.ovf, bus.diff} !== first_res) begin
      miscompares++;
      $display("FAIL b2b_first got done=%b res=%h want done=1 res=%h",
               bus.done, {bus.bout, bus.ovf, bus.diff}, first_res);
    end
    run_op(8'h10, 8'h20, edges, busy_ok);
    vectors++;
    if (edges !== W || !busy_ok) begin
      miscompares++;
      $display("FAIL b2b_restart got %0d edges busy_ok=%b want %0d edges busy_ok=1", edges, busy_ok, W);
    end
    vectors++;
    if ({bus.done, bus.bout, bus.ovf, bus.diff} !== {1'b1, second_res} || bus.diff !== 8'hF0) begin
      miscompares++;
      $display("FAIL b2b_second got done=%b bout=%b diff=%h want done=1 bout=1 diff=f0",
               bus.done, bus.bout, bus.diff);
    end
    // Repeat the back-to-back hand-off, watching that the old result stays visible.
    bus.start = 1'b1;
    bus.a = a0;
    bus.b = b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    held_bad = 0;
    edges = 0;
    while (!bus.done && edges < 4 * W) begin
      if ({bus.bout, bus.ovf, bus.diff} !== second_res) held_bad++;
      @(posedge clk); #1;
      edges++;
    end
    vectors++;
    if (held_bad !== 0 || edges !== W || {bus.bout, bus.ovf, bus.diff} !== first_res) begin
      miscompares++;
      $display("FAIL b2b_hold got %0d unstable cycles edges=%0d res=%h want 0 unstable edges=%0d res=%h",
               held_bad, edges, {bus.bout, bus.ovf, bus.diff}, W, first_res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int edges, dones;
    bit busy_ok;
    logic [W+1:0] exp_res;
    bus.start = 1'b1;
    bus.a = 8'hA5;
    bus.b = 8'h3C;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.bout, bus.ovf, bus.diff} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs got busy=%b done=%b bout=%b ovf=%b diff=%h want all 0",
               bus.busy, bus.done, bus.bout, bus.ovf, bus.diff);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < W + 4; e++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL async_reset_abort got %0d cycles with busy/done want 0", dones);
    end
    exp_res = ref_sub(8'h33, 8'h11);
    run_op(8'h33, 8'h11, edges, busy_ok);
    vectors++;
    if (edges !== W || {bus.done, bus.bout, bus.ovf, bus.diff} !== {1'b1, exp_res} || bus.diff !== 8'h22) begin
      miscompares++;
      $display("FAIL async_reset_restart got edges=%0d done=%b diff=%h want edges=%0d done=1 diff=22",
               edges, bus.done, bus.diff, W);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
